sdram_arbiter: RTL and testbench

Round-robin arbiter that shares the single system port of the SDRAM controller (sys_rd/sys_wr/sys_rdy/sys_ack handshake, 24-bit word address, 16-bit data) between NPORT requesters. It sits between client blocks (e.g. frame fetch, CPU bridge, DMA) and the controller. It serialises their word accesses, sequences the controller's rdy/ack handshake, and returns read data with a one-cycle done pulse per transaction.

---
 rtl/sdram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's single system port among
// NPORT requesters; sequences the controller's rdy/ack handshake per word access.
module sdram_arbiter #(
    parameter int NPORT    = 3,
    parameter int AW       = 24,
    parameter int DW       = 16,
    parameter int ACK_HOLD = 3
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NPORT-1:0]    req,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*DW-1:0] wdata,
    output logic [NPORT-1:0]    grant,
    output logic [NPORT-1:0]    done,
    output logic [DW-1:0]       rdata,
    output logic                sys_rd,
    output logic                sys_wr,
    output logic [AW-1:0]       sys_ab,
    output logic [DW-1:0]       sys_di,
    output logic                sys_ack,
    input  logic                sys_rdy,
    input  logic [DW-1:0]       sys_do
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = $clog2(ACK_HOLD);

    typedef enum logic [2:0] {FLUSH, IDLE, ISSUE, BUSY, ACK} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NPORT-1:0]  grant_q, grant_d;
    logic [NPORT-1:0]  done_q, done_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rd_q, rd_d, wr_q, wr_d, ack_q, ack_d;
    logic [AW-1:0]     ab_q, ab_d;
    logic [DW-1:0]     di_q, di_d;

    // Scan ports ptr+NPORT down to ptr+1 so the last hit is the first requester after ptr.
    logic [PW-1:0] win;
    logic          any_req;
    int            idx;
    int            widx;
    always_comb begin
        win     = ptr_q;
        any_req = 1'b0;
        idx     = 0;
        for (int k = NPORT; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NPORT) idx = idx - NPORT;
            if (req[idx]) begin
                win     = PW'(idx);
                any_req = 1'b1;
            end
        end
        widx = int'(win);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        rdata_d = rdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ab_d    = ab_q;
        di_d    = di_q;
        ack_d   = ack_q;
        case (state_q)
            FLUSH, ACK: begin
                if (cnt_q == '0) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            IDLE: begin
                // sys_rdy low means init/refresh or the previous cycle is still closing
                if (sys_rdy && any_req) begin
                    grant_d       = '0;
                    grant_d[win]  = 1'b1;
                    ab_d          = addr[widx*AW +: AW];
                    di_d          = wdata[widx*DW +: DW];
                    rd_d          = ~we[win];
                    wr_d          = we[win];
                    ptr_d         = win;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (!sys_rdy) state_d = BUSY;
            end
            BUSY: begin
                if (sys_rdy) begin
                    if (rd_q) rdata_d = sys_do;
                    done_d  = grant_q;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    grant_d = '0;
                    cnt_d   = CW'(ACK_HOLD - 1);
                    state_d = ACK;
                end
            end
            default: state_d = FLUSH;
        endcase
    end

    // Reset enters FLUSH with ack high to release a controller abandoned mid-cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= FLUSH;
            cnt_q   <= CW'(ACK_HOLD - 1);
            ptr_q   <= PW'(NPORT - 1);
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ab_q    <= '0;
            di_q    <= '0;
            ack_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ab_q    <= ab_d;
            di_q    <= di_d;
            ack_q   <= ack_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign sys_rd  = rd_q;
    assign sys_wr  = wr_q;
    assign sys_ab  = ab_q;
    assign sys_di  = di_q;
    assign sys_ack = ack_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural controller, transaction-level arbiter
// model checked every cycle, plus directed literal checks.
module tb_sdram_arbiter;
    localparam int NPORT = 3, AW = 24, DW = 16, ACK_HOLD = 3;

    logic sys_clk, sys_rst;
    logic [NPORT-1:0] req, we, grant, done;
    logic [NPORT*AW-1:0] addr;
    logic [NPORT*DW-1:0] wdata;
    logic [DW-1:0] rdata, sys_di, sys_do;
    logic [AW-1:0] sys_ab;
    logic sys_rd, sys_wr, sys_ack, sys_rdy;

    int n_chk = 0, n_pass = 0;

    sdram_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW), .ACK_HOLD(ACK_HOLD)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .grant(grant), .done(done), .rdata(rdata), .sys_rd(sys_rd),
        .sys_wr(sys_wr), .sys_ab(sys_ab), .sys_di(sys_di), .sys_ack(sys_ack),
        .sys_rdy(sys_rdy), .sys_do(sys_do));

    initial begin
        sys_clk = 0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic sample();
        @(posedge sys_clk);
        #1;
    endtask

    // ---------------- controller model ----------------
    logic [15:0] cmem [256];
    logic [15:0] exp_mem [256];
    int  cst = 0, ccnt = 0, init_cnt = 0, wr_cnt = 0;
    bit  refresh = 0, ref_used = 0;
    logic [23:0] c_addr;
    logic        c_we;
    logic [15:0] c_di, last_di;

    initial begin
        for (int i = 0; i < 256; i++) begin
            cmem[i]    = 16'hC000 | 16'(i);
            exp_mem[i] = 16'hC000 | 16'(i);
        end
        cmem[8'h45]    = 16'hBEEF;
        exp_mem[8'h45] = 16'hBEEF;
        sys_rdy = 1;
        sys_do  = 0;
        last_di = 0;
        forever begin
            @(negedge sys_clk);
            case (cst)
                0: if (init_cnt > 0) begin
                       init_cnt--;
                       sys_rdy = 0;
                   end else if ((sys_rd || sys_wr) && !sys_ack) begin
                       c_addr = sys_ab; c_we = sys_wr; c_di = sys_di;
                       if (c_we) begin wr_cnt++; last_di = sys_di; end
                       sys_rdy = 0;
                       if (refresh) begin refresh = 0; ref_used = 1; ccnt = 5; cst = 1; end
                       else begin ccnt = 4; cst = 2; end
                   end else sys_rdy = 1;
                1: begin ccnt--; if (ccnt == 0) begin ccnt = 4; cst = 2; end end
                2: begin
                       ccnt--;
                       if (ccnt == 0) begin
                           if (c_we) cmem[c_addr[7:0]] = c_di;
                           else sys_do = cmem[c_addr[7:0]];
                           sys_rdy = 1;
                           cst = 3;
                       end
                   end
                3: if (sys_ack) cst = 4;
                default: if (!sys_ack) cst = 0;
            endcase
        end
    end

    // ---------------- arbiter model + per-cycle compare ----------------
    int  m_out, m_ackleft, m_ptr;
    bit  m_acc, m_we, m_idle;
    logic [23:0] m_ab;
    logic [15:0] m_di, m_rdata;
    logic [2:0]  m_done, m_grant;

    initial begin
        m_out = -1; m_ackleft = ACK_HOLD; m_ptr = NPORT - 1; m_acc = 0; m_we = 0;
        m_ab = 0; m_di = 0; m_rdata = 0;
        forever begin
            sample();
            m_done = '0;
            if (sys_rst) begin
                m_out = -1; m_acc = 0; m_ackleft = ACK_HOLD; m_ptr = NPORT - 1;
                m_we = 0; m_ab = 0; m_di = 0; m_rdata = 0;
            end else begin
                m_idle = (m_ackleft == 0) && (m_out < 0);
                if (m_ackleft > 0) m_ackleft--;
                if (m_idle) begin
                    if (sys_rdy && req != 0) begin
                        for (int k = 1; k <= NPORT && m_out < 0; k++)
                            if (req[(m_ptr + k) % NPORT]) m_out = (m_ptr + k) % NPORT;
                        m_ptr = m_out; m_acc = 0;
                        m_we = we[m_out];
                        m_ab = addr[m_out*AW +: AW];
                        m_di = wdata[m_out*DW +: DW];
                    end
                end else if (m_out >= 0 && !m_acc) begin
                    if (!sys_rdy) m_acc = 1;
                end else if (m_out >= 0 && sys_rdy) begin
                    m_done[m_out] = 1'b1;
                    if (m_we) exp_mem[m_ab[7:0]] = m_di;
                    else m_rdata = exp_mem[m_ab[7:0]];
                    m_out = -1;
                    m_ackleft = ACK_HOLD;
                end
            end
            m_grant = (m_out >= 0) ? (3'b001 << m_out) : 3'b000;
            chk("cyc_grant", grant, m_grant);
            chk("cyc_done", done, m_done);
            chk("cyc_rd_wr_ack", {sys_rd, sys_wr, sys_ack},
                {(m_out >= 0) && !m_we, (m_out >= 0) && m_we, m_ackleft > 0});
            chk("cyc_rdata", rdata, m_rdata);
            chk("cyc_sys_ab", sys_ab, m_ab);
            chk("cyc_sys_di", sys_di, m_di);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(output logic [2:0] dn);
        dn = 0;
        for (int i = 0; i < 300; i++) begin
            sample();
            if (done != 0) begin dn = done; break; end
        end
    endtask

    task automatic txn(input int p, input bit w, input logic [23:0] a, input logic [15:0] d,
                       output logic [2:0] dn);
        @(negedge sys_clk);
        req[p] = 1; we[p] = w; addr[p*AW +: AW] = a; wdata[p*DW +: DW] = d;
        wait_done(dn);
        @(negedge sys_clk);
        req[p] = 0;
    endtask

    function automatic int oh_idx(input logic [2:0] v);
        case (v)
            3'b001: return 0;
            3'b010: return 1;
            3'b100: return 2;
            default: return 7;
        endcase
    endfunction

    initial begin
        logic [2:0] dn;
        int ackc, cnt, early, w0, nd, bad;
        bit risen, gs;
        int order [9];
        req = 0; we = 0; addr = 0; wdata = 0; sys_rst = 0;
        #2 sys_rst = 1;
        #1;
        chk("rst_grant", grant, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_rd_wr", {sys_rd, sys_wr}, 2'b00);
        chk("rst_ack", sys_ack, 1'b1);
        chk("rst_rdata", rdata, 16'h0000);
        repeat (3) @(negedge sys_clk);
        sys_rst = 0;
        repeat (5) @(negedge sys_clk);

        // single read, port 1
        req[1] = 1; we[1] = 0; addr[1*AW +: AW] = 24'h012345;
        sample();
        chk("rd_latency", {sys_rd, grant}, {1'b1, 3'b010});
        wait_done(dn);
        chk("rd1_done", dn, 3'b010);
        chk("rd1_rdata", rdata, 16'hBEEF);
        ackc = int'(sys_ack);
        @(negedge sys_clk);
        req[1] = 0;
        repeat (5) begin sample(); ackc += int'(sys_ack); end
        chk("rd1_ack_len", ackc, 3);

        // write then read back, port 2
        txn(2, 1, 24'hFFFFFF, 16'hA5A5, dn);
        chk("wr2_done", dn, 3'b100);
        chk("wr2_keeps_rdata", rdata, 16'hBEEF);
        txn(2, 0, 24'hFFFFFF, 16'h0000, dn);
        chk("rd2_done", dn, 3'b100);
        chk("rd2_rdata", rdata, 16'hA5A5);

        // round robin, all ports continuously requesting
        @(negedge sys_clk);
        for (int p = 0; p < NPORT; p++) begin
            we[p] = 0;
            addr[p*AW +: AW] = 24'h000100 + 24'(p);
        end
        req = 3'b111;
        for (int i = 0; i < 9; i++) order[i] = -1;
        cnt = 0;
        for (int i = 0; i < 600 && cnt < 9; i++) begin
            sample();
            if (done != 0) begin order[cnt] = oh_idx(done); cnt++; end
        end
        @(negedge sys_clk);
        req = 0;
        for (int i = 0; i < 9; i++) chk("rr_order", order[i], i % 3);

        // init gating: controller holds rdy low for 200 cycles after reset
        repeat (6) @(negedge sys_clk);
        sys_rst = 1;
        init_cnt = 200;
        w0 = wr_cnt;
        repeat (2) @(negedge sys_clk);
        sys_rst = 0;
        req[0] = 1; we[0] = 1; addr[0 +: AW] = 24'h000010; wdata[0 +: DW] = 16'h1234;
        early = 0; risen = 0; dn = 0;
        for (int i = 0; i < 400; i++) begin
            sample();
            if (sys_rdy) risen = 1;
            if (!risen && sys_wr) early++;
            if (done != 0) begin dn = done; break; end
        end
        @(negedge sys_clk);
        req[0] = 0;
        chk("init_no_early_wr", early, 0);
        chk("init_done", dn, 3'b001);
        chk("init_wr_count", wr_cnt - w0, 1);
        chk("init_wr_data", last_di, 16'h1234);

        // refresh before the controller accepts the read
        refresh = 1;
        req[0] = 1; we[0] = 0; addr[0 +: AW] = 24'h000010;
        nd = 0; bad = 0; gs = 0; dn = 0;
        for (int i = 0; i < 80; i++) begin
            sample();
            if (grant == 3'b001) gs = 1;
            if (done != 0) begin
                nd++; dn = done;
                @(negedge sys_clk);
                req[0] = 0;
            end else if (gs && nd == 0 && grant != 3'b001) bad++;
        end
        chk("ref_single_done", nd, 1);
        chk("ref_done_port", dn, 3'b001);
        chk("ref_rdata", rdata, 16'h1234);
        chk("ref_grant_held", bad, 0);
        chk("ref_used", ref_used, 1'b1);

        // reset while BUSY
        @(negedge sys_clk);
        req[1] = 1; we[1] = 0; addr[1*AW +: AW] = 24'h012345;
        for (int i = 0; i < 60; i++) begin
            sample();
            if (grant == 3'b010 && !sys_rdy) break;
        end
        @(negedge sys_clk);
        sys_rst = 1;
        req[1] = 0;
        #1;
        chk("rstmid_outputs", {grant, done, sys_rd, sys_wr}, 8'h00);
        chk("rstmid_ack", sys_ack, 1'b1);
        for (int i = 0; i < 60; i++) begin
            sample();
            if (sys_rdy) break;
        end
        sample();
        @(negedge sys_clk);
        sys_rst = 0;
        #1;
        ackc = int'(sys_ack);
        repeat (5) begin sample(); ackc += int'(sys_ack); end
        chk("flush_ack_len", ackc, 3);
        txn(2, 0, 24'h012345, 16'h0000, dn);
        chk("post_rst_done", dn, 3'b100);
        chk("post_rst_rdata", rdata, 16'hBEEF);

        repeat (5) sample();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
